// File: rtl/neo_pattern_seq.sv
// NeoPixel frame sequencer: builds solid/chase/ramp/off frames and drives the
// driver's load/send handshake. Define NEO_GAMMA_EN for the squared-level gamma.
module neo_pattern_seq #(
  parameter int unsigned        NUM_PIXELS = 5,
  parameter int unsigned        LEVEL_W    = 8,
  parameter int unsigned        FRAME_DIV  = 1000,
  parameter logic [LEVEL_W-1:0] PIX_OFFSET = 8'h33,
  localparam int unsigned       PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [LEVEL_W-1:0] step,
  input  logic               ready_to_load,
  input  logic               ready_to_send,
  output logic [PIX_W-1:0]   pixel_index,
  output logic [1:0]         color_index,
  output logic [LEVEL_W-1:0] color_level,
  output logic               load_color,
  output logic               send_it,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned    HOLD_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_e;
  typedef enum logic [1:0] {MODE_SOLID, MODE_CHASE, MODE_RAMP, MODE_OFF} mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [1:0]          col_q, col_d;
  logic [LEVEL_W-1:0]  ramp_q, ramp_d;
  logic [LEVEL_W-1:0]  phase_q, phase_d;
  logic [PIX_W-1:0]    fcnt_q, fcnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [LEVEL_W-1:0]  level_lin, level_out, ramp_red;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_SOLID;
      pix_q   <= '0;
      col_q   <= '0;
      ramp_q  <= '0;
      phase_q <= '0;
      fcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      ramp_q  <= ramp_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pix_d      = pix_q;
    col_d      = col_q;
    ramp_d     = ramp_q;
    phase_d    = phase_q;
    fcnt_d     = fcnt_q;
    hold_d     = hold_q;
    load_color = 1'b0;
    send_it    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = LOAD;
          mode_d  = mode_e'(mode);
          pix_d   = '0;
          col_d   = '0;
          ramp_d  = '0;
        end
      end
      LOAD: begin
        if (ready_to_load) begin
          load_color = 1'b1;
          if (col_q == 2'd2) begin
            col_d = '0;
            if (pix_q == LAST_PIX) begin
              pix_d   = '0;
              ramp_d  = '0;
              state_d = SEND;
            end else begin
              pix_d  = pix_q + 1'b1;
              // running sum tracks pixel * PIX_OFFSET without a multiplier
              ramp_d = ramp_q + PIX_OFFSET;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      SEND: begin
        if (ready_to_send) begin
          send_it = 1'b1;
          state_d = HOLD;
          phase_d = phase_q + step;
          fcnt_d  = (fcnt_q == LAST_PIX) ? '0 : fcnt_q + 1'b1;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == LAST_HOLD) begin
          hold_d = '0;
          if (run) begin
            state_d = LOAD;
            mode_d  = mode_e'(mode);
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_lin = '0;
    ramp_red  = phase_q + ramp_q;
    case (mode_q)
      MODE_SOLID: if (col_q == 2'd0) level_lin = phase_q;
      MODE_CHASE: if (pix_q == fcnt_q) level_lin = '1;
      MODE_RAMP: begin
        if (col_q == 2'd0)      level_lin = ramp_red;
        else if (col_q == 2'd1) level_lin = ~ramp_red;
      end
      MODE_OFF:   level_lin = '0;
      default:    level_lin = '0;
    endcase
  end

`ifdef NEO_GAMMA_EN
  logic [2*LEVEL_W-1:0] level_sq;
  always_comb begin
    level_sq  = {{LEVEL_W{1'b0}}, level_lin} * {{LEVEL_W{1'b0}}, level_lin};
    level_out = LEVEL_W'(level_sq >> LEVEL_W);
  end
`else
  always_comb level_out = level_lin;
`endif

  always_comb begin
    pixel_index = load_color ? pix_q : '0;
    color_index = load_color ? col_q : '0;
    color_level = load_color ? level_out : '0;
    frame_done  = send_it;
    busy        = (state_q != IDLE);
  end

endmodule

// File: doc/neo_pattern_seq.md
# neo_pattern_seq

Parametrised NeoPixel frame sequencer that drives the pixel driver's load/send handshake. It generates complete frames for a chain of `NUM_PIXELS` RGB pixels in one of four selectable animation modes. It advances an animation phase between frames and inserts a programmable inter-frame hold. It replaces the fixed 4-pixel, free-running test pattern generator as the color source in front of the NeoPixel driver.

## Interface
- `NUM_PIXELS`, 5: pixels in the chain, ≥1.
- `LEVEL_W`, 8: color level width.
- `FRAME_DIV`, 1000: hold cycles between `send_it` and the next frame's first load, ≥1.
- `PIX_OFFSET`, 8'h33: per-pixel phase offset in ramp mode (`LEVEL_W` bits).
- Localparam `PIX_W` = max(1, $clog2(`NUM_PIXELS`)).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; frames generated while high.
- `mode` in 2: 0 solid, 1 chase, 2 ramp, 3 off; sampled at frame start.
- `step` in `LEVEL_W`: phase increment per frame; sampled at frame end.
- `ready_to_load` in 1: driver accepts a color load this cycle.
- `ready_to_send` in 1: driver accepts a send this cycle.
- `pixel_index` out `PIX_W`: pixel being loaded.
- `color_index` out 2: 0 red, 1 green, 2 blue.
- `color_level` out `LEVEL_W`: level being loaded.
- `load_color` out 1: one-cycle load strobe.
- `send_it` out 1: one-cycle send strobe.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse, coincident with `send_it`.

## Operation
- States: IDLE, LOAD, SEND, HOLD.
- IDLE → LOAD when `run`=1. On that entry, latch `mode`; pixel counter and color counter are 0.
- LOAD:
  - `load_color` = `ready_to_load`, combinational (Mealy).
  - When it is asserted, it drives the current pixel, color, and level, then advances color 0→1→2→0 and increments pixel on the color wrap.
  - The load of (`NUM_PIXELS`-1, 2) moves the FSM to SEND.
- SEND: `send_it` = `frame_done` = `ready_to_send`. When asserted, move to HOLD and set phase ← phase + `step`, mod 2^`LEVEL_W`.
- HOLD: count `FRAME_DIV` cycles. Then go to LOAD if `run`=1 (re-latch `mode`), else IDLE.
- Dropping `run` mid-frame does not abort. The frame completes and the FSM returns to IDLE after HOLD.
- `ready_to_send` is ignored outside SEND. `ready_to_load` is ignored outside LOAD. When both are high in LOAD, only the load is performed.
- Mode levels, before gamma (p = pixel, c = color, F = all ones):
  - Solid: red = phase; green = blue = 0.
  - Chase: all colors = F for p == frame_cnt mod `NUM_PIXELS`, else 0. frame_cnt increments at send and wraps at `NUM_PIXELS`.
  - Ramp: red = phase + p·`PIX_OFFSET` (truncated); green = ~red; blue = 0.
  - Off: 0.
- `pixel_index`, `color_index`, and `color_level` are 0 whenever `load_color`=0.

## Timing
- Reset, and any reset mid-operation: next state IDLE, phase 0, frame_cnt 0, all counters 0. All outputs 0 in the cycle after reset is sampled.
- `run` rising in IDLE: LOAD entered next cycle. The first load can occur in that cycle.
- With `ready_to_load` held high, 3·`NUM_PIXELS` loads occur in consecutive cycles.
- With `ready_to_send` high, `send_it` occurs in the cycle after the last load.
- Between `send_it` and the next frame's first load there are exactly `FRAME_DIV` HOLD cycles.
- Minimum frame period: 3·`NUM_PIXELS` + 1 + `FRAME_DIV` cycles.
- Stalls on either ready input extend the current state indefinitely, with no output strobes.

## Configuration
- `NEO_GAMMA_EN` defined: `color_level` = (L·L) >> `LEVEL_W` applied to the mode level L. Examples for 8 bits: 0x80 → 0x40, 0xFF → 0xFE, 0x01 → 0x00. The gamma stage is combinational, with no added latency.
- `NEO_GAMMA_EN` undefined: `color_level` = L (linear).

## Test plan
Bench defaults: `NUM_PIXELS`=5, `LEVEL_W`=8, `FRAME_DIV`=4, gamma off unless stated.

- Reset: assert `reset` with `run`=1 → all outputs 0 and `busy`=0 the next cycle; reset mid-LOAD → IDLE, and the next frame's solid red level = 0x00.
- Solid mode, `step`=0x10, both ready inputs high:
  - 15 consecutive load strobes in order (0,0),(0,1),(0,2),(1,0)…(4,2), then `send_it`.
  - Levels: red 0x00, green/blue 0; next frame red 0x10.
  - 4 idle cycles between frames.
- Chase mode: frames 0–5 light pixels 0,1,2,3,4,0 at 0xFF on all colors; all other loads 0x00.
- Phase wrap with `step`=0x80 → solid red across frames 0x00, 0x80, 0x00. Ramp mode at phase 0 → pixel 2 red 0x66, green 0x99.
- Handshake stalls:
  - `ready_to_load` toggles each cycle → loads only in high cycles.
  - `ready_to_send` held low 10 cycles → no `send_it` until it rises.
  - Both ready inputs high in LOAD → load only.
  - `run` dropped mid-frame → frame completes, then IDLE.
- `NEO_GAMMA_EN`, solid mode, phases 0x80 and 0xFF → `color_level` 0x40 and 0xFE.
